// File: rtl/scope_pkg.sv
// Shared scope display constants, bus-owner/FSM enums and the row-to-word mapping.
package scope_pkg;

    localparam int unsigned WORDS_PER_COL = 25;
    localparam int unsigned NUM_COLS      = 640;
    localparam int unsigned NUM_ROWS      = 400;

    typedef enum logic {
        OWN_VGA,
        OWN_WR
    } owner_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_POP,
        ST_PARK
    } wr_state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } sample_t;

    typedef struct packed {
        logic [4:0] word;
        logic [3:0] bit_idx;
    } row_map_t;

    // Row y lives in 16-row block k = y/16; block 0 is word 0, block k>0 is word 25-k,
    // and the row's bit counts down from the MSB within its word.
    function automatic row_map_t row_to_word(input logic [8:0] y);
        row_map_t   m;
        logic [4:0] k;
        k         = y[8:4];
        m.word    = (k == 5'd0) ? 5'd0 : 5'(WORDS_PER_COL) - k;
        m.bit_idx = 4'd15 - y[3:0];
        return m;
    endfunction

endpackage

// File: rtl/ram_write_arbiter_if.sv
// Sample handshake, VGA pass-through controls and SRAM pin bundle.
interface ram_write_arbiter_if;
    logic        VGA_RAM_ACCESS_OK;
    logic [17:0] VGA_RAM_ADDR;
    logic        VGA_RAM_OE;
    logic        VGA_RAM_WE;
    logic        VGA_RAM_CS;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY;
    logic [9:0]  SAMPLE_X;
    logic [8:0]  SAMPLE_Y;
    logic [17:0] RAM_ADDR;
    logic [15:0] RAM_DQ_OUT;
    logic        RAM_DQ_OE;
    logic        RAM_OE;
    logic        RAM_WE;
    logic        RAM_CS;
    logic        BUSY;
    logic        DROP;

    modport slave (
        input  VGA_RAM_ACCESS_OK, VGA_RAM_ADDR, VGA_RAM_OE, VGA_RAM_WE, VGA_RAM_CS,
        input  SAMPLE_VALID, SAMPLE_X, SAMPLE_Y,
        output SAMPLE_READY, RAM_ADDR, RAM_DQ_OUT, RAM_DQ_OE, RAM_OE, RAM_WE, RAM_CS,
        output BUSY, DROP
    );

    modport master (
        output VGA_RAM_ACCESS_OK, VGA_RAM_ADDR, VGA_RAM_OE, VGA_RAM_WE, VGA_RAM_CS,
        output SAMPLE_VALID, SAMPLE_X, SAMPLE_Y,
        input  SAMPLE_READY, RAM_ADDR, RAM_DQ_OUT, RAM_DQ_OE, RAM_OE, RAM_WE, RAM_CS,
        input  BUSY, DROP
    );
endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO of plotted samples; exposes the head and the entry behind it.
module sample_fifo
    import scope_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  sample_t                    push_data,
    input  logic                       pop,
    output sample_t                    head,
    output sample_t                    second,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    sample_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == CW'(0));
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign second = mem_q[rd_ptr_q + AW'(1)];

    // Pointer and occupancy update; a pop frees the slot a simultaneous push needs.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    // Pointer/count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// Shares the waveform SRAM between VGA scan-out and column rewrites of plotted samples.
module ram_write_arbiter #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned WORDS_PER_COL = scope_pkg::WORDS_PER_COL,
    parameter int unsigned NUM_COLS      = scope_pkg::NUM_COLS,
    parameter int unsigned NUM_ROWS      = scope_pkg::NUM_ROWS
) (
    input  logic               CLK_50MHZ,
    input  logic               MASTER_RST,
    ram_write_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    scope_pkg::wr_state_e state_q, state_d;
    scope_pkg::owner_e    owner;
    scope_pkg::sample_t   in_smp, head, second;
    scope_pkg::row_map_t  map;
    logic [4:0]           word_q, word_d;
    logic                 drop_q, drop_d;
    logic                 fifo_push, fifo_pop, full, empty;
    logic [CW-1:0]        count;
    logic                 head_ok, second_ok, last_word;
    logic [17:0]          wr_addr;
    logic [15:0]          wr_dq;
    logic                 wr_cs, wr_we, wr_dq_oe;

    // Input side: clamp rows below the plot area, accept whenever there is room.
    always_comb begin
        in_smp.x         = bus.SAMPLE_X;
        in_smp.y         = (bus.SAMPLE_Y > 9'(NUM_ROWS - 1)) ? 9'(NUM_ROWS - 1) : bus.SAMPLE_Y;
        bus.SAMPLE_READY = !full && !MASTER_RST;
        fifo_push        = bus.SAMPLE_VALID && bus.SAMPLE_READY;
    end

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK_50MHZ),
        .rst       (MASTER_RST),
        .push      (fifo_push),
        .push_data (in_smp),
        .pop       (fifo_pop),
        .head      (head),
        .second    (second),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign head_ok   = (head.x < 10'(NUM_COLS));
    assign second_ok = (second.x < 10'(NUM_COLS));
    assign last_word = (word_q == 5'(WORDS_PER_COL - 1));
    assign map       = scope_pkg::row_to_word(head.y);

    // Next-state: off-screen heads are discarded from IDLE, and the word index survives a park.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        drop_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            scope_pkg::ST_IDLE: begin
                if (!empty) begin
                    if (!head_ok) begin
                        fifo_pop = 1'b1;
                        drop_d   = 1'b1;
                    end else if (bus.VGA_RAM_ACCESS_OK) begin
                        state_d = scope_pkg::ST_TURN;
                    end
                end
            end
            scope_pkg::ST_TURN:   state_d = scope_pkg::ST_SETUP;
            scope_pkg::ST_SETUP:  state_d = scope_pkg::ST_STROBE;
            scope_pkg::ST_STROBE: state_d = scope_pkg::ST_RELEASE;
            scope_pkg::ST_RELEASE: begin
                if (last_word) begin
                    state_d = scope_pkg::ST_POP;
                end else begin
                    word_d  = word_q + 5'd1;
                    state_d = bus.VGA_RAM_ACCESS_OK ? scope_pkg::ST_SETUP : scope_pkg::ST_PARK;
                end
            end
            scope_pkg::ST_POP: begin
                fifo_pop = 1'b1;
                word_d   = 5'd0;
                if (count > CW'(1) && second_ok && bus.VGA_RAM_ACCESS_OK)
                    state_d = scope_pkg::ST_SETUP;
                else
                    state_d = scope_pkg::ST_PARK;
            end
            scope_pkg::ST_PARK: state_d = scope_pkg::ST_IDLE;
            default:            state_d = scope_pkg::ST_IDLE;
        endcase
    end

    // State, word index and drop pulse registers; reset abandons any column in flight.
    always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            state_q <= scope_pkg::ST_IDLE;
            word_q  <= 5'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            drop_q  <= drop_d;
        end
    end

    // Writer-side bus decode from the current state and word.
    always_comb begin
        wr_cs    = 1'b1;
        wr_we    = 1'b1;
        wr_dq_oe = 1'b0;
        wr_dq    = 16'h0000;
        wr_addr  = 18'(head.x) * 18'(WORDS_PER_COL) + 18'(word_q);
        case (state_q)
            scope_pkg::ST_SETUP, scope_pkg::ST_STROBE, scope_pkg::ST_RELEASE: begin
                wr_cs    = 1'b0;
                wr_dq_oe = 1'b1;
                wr_we    = (state_q != scope_pkg::ST_STROBE);
                if (word_q == map.word) wr_dq = 16'(1) << map.bit_idx;
            end
            default: ;
        endcase
    end

    // Pin mux: VGA controls pass straight through whenever the writer does not own the bus.
    always_comb begin
        owner          = (state_q == scope_pkg::ST_IDLE) ? scope_pkg::OWN_VGA : scope_pkg::OWN_WR;
        bus.RAM_ADDR   = bus.VGA_RAM_ADDR;
        bus.RAM_OE     = bus.VGA_RAM_OE;
        bus.RAM_WE     = bus.VGA_RAM_WE;
        bus.RAM_CS     = bus.VGA_RAM_CS;
        bus.RAM_DQ_OE  = 1'b0;
        bus.RAM_DQ_OUT = wr_dq;
        if (owner == scope_pkg::OWN_WR) begin
            bus.RAM_ADDR  = wr_addr;
            bus.RAM_OE    = 1'b1;
            bus.RAM_WE    = wr_we;
            bus.RAM_CS    = wr_cs;
            bus.RAM_DQ_OE = wr_dq_oe;
        end
        bus.BUSY = !empty;
        bus.DROP = drop_q;
    end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Scoreboard bench: stimulus queues expected SRAM writes, a negedge monitor checks them.
module tb_ram_write_arbiter;

    logic clk;
    logic rst;
    ram_write_arbiter_if bus ();

    ram_write_arbiter dut (
        .CLK_50MHZ  (clk),
        .MASTER_RST (rst),
        .bus        (bus)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           wr_seen = 0;
    int           drop_cnt = 0;
    int           cyc = 0;
    logic         expect_vga = 1'b0;
    logic [33:0]  exp_q [$];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // VGA reader model: moving read address in a range the writer never uses.
    initial begin
        bus.VGA_RAM_ADDR = 18'h20000;
        bus.VGA_RAM_OE   = 1'b0;
        bus.VGA_RAM_WE   = 1'b1;
        bus.VGA_RAM_CS   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            bus.VGA_RAM_ADDR = 18'h20000 + 18'(cyc % 4096);
            bus.VGA_RAM_OE   = cyc[0];
        end
    end

    // Monitor: every write strobe pops one expectation; optionally checks VGA pass-through.
    always @(negedge clk) begin
        if (bus.RAM_WE === 1'b0 && bus.RAM_CS === 1'b0) begin
            logic [33:0] e;
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.RAM_ADDR, bus.RAM_DQ_OUT);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.RAM_ADDR), 32'(e[33:16]));
                check("write_data", 32'(bus.RAM_DQ_OUT), 32'(e[15:0]));
            end
        end
        if (bus.DROP === 1'b1) drop_cnt++;
        if (expect_vga) begin
            check("vga_addr", 32'(bus.RAM_ADDR), 32'(bus.VGA_RAM_ADDR));
            check("vga_oe", 32'(bus.RAM_OE), 32'(bus.VGA_RAM_OE));
            check("vga_we", 32'(bus.RAM_WE), 32'(bus.VGA_RAM_WE));
            check("vga_cs", 32'(bus.RAM_CS), 32'(bus.VGA_RAM_CS));
            check("vga_dq_oe", 32'(bus.RAM_DQ_OE), 32'd0);
        end
    end

    // Offer one sample; on acceptance of an on-screen column queue its 25 expected writes.
    task automatic push(input int x, input int y, input int hot_w, input logic [15:0] hot_d,
                        input logic exp_ready);
        @(negedge clk);
        bus.SAMPLE_X     = 10'(x);
        bus.SAMPLE_Y     = 9'(y);
        bus.SAMPLE_VALID = 1'b1;
        #1;
        check("sample_ready", 32'(bus.SAMPLE_READY), 32'(exp_ready));
        if (exp_ready && x < 640) begin
            for (int w = 0; w < 25; w++)
                exp_q.push_back({18'(x * 25 + w), (w == hot_w) ? hot_d : 16'h0000});
        end
        @(posedge clk);
        @(negedge clk);
        bus.SAMPLE_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (bus.BUSY === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < limit), 32'd1);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (wr_seen < target && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("write_progress_timeout", 32'(n < 500), 32'd1);
    endtask

    initial begin
        int n;
        int base;
        int d0;
        rst                   = 1'b1;
        bus.SAMPLE_VALID      = 1'b0;
        bus.SAMPLE_X          = '0;
        bus.SAMPLE_Y          = '0;
        bus.VGA_RAM_ACCESS_OK = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.SAMPLE_READY), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_drop", 32'(bus.DROP), 32'd0);
        check("rst_dq_oe", 32'(bus.RAM_DQ_OE), 32'd0);
        check("rst_dq_out", 32'(bus.RAM_DQ_OUT), 32'd0);
        check("rst_addr", 32'(bus.RAM_ADDR), 32'(bus.VGA_RAM_ADDR));
        check("rst_we", 32'(bus.RAM_WE), 32'(bus.VGA_RAM_WE));
        check("rst_cs", 32'(bus.RAM_CS), 32'(bus.VGA_RAM_CS));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.SAMPLE_READY), 32'd1);

        // (0,0): word 0 = 0x8000, BUSY high for 78 cycles
        push(0, 0, 0, 16'h8000, 1'b1);
        n = 0;
        while (bus.BUSY === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd78);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // (2,17): address 74 = 0x4000
        push(2, 17, 24, 16'h4000, 1'b1);
        wait_idle("col2_timeout", 300);

        // Window closed: four accepted, fifth refused, VGA keeps the bus
        @(negedge clk);
        #1;
        bus.VGA_RAM_ACCESS_OK = 1'b0;
        expect_vga            = 1'b1;
        push(5, 0, 0, 16'h8000, 1'b1);
        push(6, 16, 24, 16'h8000, 1'b1);
        push(7, 399, 1, 16'h0001, 1'b1);
        push(8, 100, 19, 16'h0800, 1'b1);
        push(9, 0, 0, 16'h8000, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        expect_vga            = 1'b0;
        bus.VGA_RAM_ACCESS_OK = 1'b1;
        wait_idle("burst_timeout", 1000);

        // Window closes during word 10 strobe, then resumes at word 11
        push(3, 32, 23, 16'h8000, 1'b1);
        base = wr_seen;
        wait_writes(base + 11);
        bus.VGA_RAM_ACCESS_OK = 1'b0;
        n = 0;
        while (!(bus.RAM_DQ_OE === 1'b0 && bus.RAM_ADDR === bus.VGA_RAM_ADDR &&
                 bus.RAM_CS === bus.VGA_RAM_CS) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bus_return_cycles_le3", 32'(n <= 3), 32'd1);
        check("writes_at_park", 32'(wr_seen - base), 32'd11);
        #1;
        expect_vga = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        expect_vga            = 1'b0;
        bus.VGA_RAM_ACCESS_OK = 1'b1;
        wait_idle("resume_timeout", 300);
        check("writes_total_resume", 32'(wr_seen - base), 32'd25);

        // Off-screen column dropped; y=450 clamps to row 399
        d0 = drop_cnt;
        push(700, 5, 0, 16'h0000, 1'b1);
        repeat (10) @(negedge clk);
        check("drop_pulses", 32'(drop_cnt - d0), 32'd1);
        check("busy_after_drop", 32'(bus.BUSY), 32'd0);
        push(4, 450, 1, 16'h0001, 1'b1);
        wait_idle("clamp_timeout", 300);

        // Reset during a strobe
        push(1, 0, 0, 16'h8000, 1'b1);
        base = wr_seen;
        wait_writes(base + 3);
        rst = 1'b1;
        #1;
        check("rst_mid_we", 32'(bus.RAM_WE), 32'(bus.VGA_RAM_WE));
        check("rst_mid_cs", 32'(bus.RAM_CS), 32'(bus.VGA_RAM_CS));
        check("rst_mid_dq_oe", 32'(bus.RAM_DQ_OE), 32'd0);
        check("rst_mid_busy", 32'(bus.BUSY), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst  = 1'b0;
        base = wr_seen;
        repeat (100) @(negedge clk);
        check("no_writes_after_rst", 32'(wr_seen - base), 32'd0);
        check("busy_after_rst", 32'(bus.BUSY), 32'd0);
        check("ready_after_mid_rst", 32'(bus.SAMPLE_READY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_write_arbiter.md
# ram_write_arbiter

Shares the single asynchronous waveform SRAM between the VGA scan-out reader and the acquisition path. Accepts plotted samples (column, level) over a valid/ready handshake and buffers them in a small FIFO. For each sample it rewrites one full 25-word display column, but only while the VGA driver reports that RAM access is safe. Sits between the capture/decimation logic and the SRAM pins; the VGA driver's RAM controls pass through it.

## Interface
Parameters:
- FIFO_DEPTH, 4: sample FIFO entries (power of two).
- WORDS_PER_COL, 25: 16-bit words per display column.
- NUM_COLS, 640: display columns.
- NUM_ROWS, 400: display rows.

Ports:
- CLK_50MHZ  in  1  system clock.
- MASTER_RST  in  1  asynchronous, active-high reset.
- VGA_RAM_ACCESS_OK  in  1  high = VGA not reading the SRAM.
- VGA_RAM_ADDR  in  18  VGA read address.
- VGA_RAM_OE, VGA_RAM_WE, VGA_RAM_CS  in  1 each  VGA active-low controls.
- SAMPLE_VALID  in  1  sample offered.
- SAMPLE_READY  out  1  FIFO not full.
- SAMPLE_X  in  10  column 0..639.
- SAMPLE_Y  in  9  row 0..399, 0 = top.
- RAM_ADDR  out  18  SRAM address.
- RAM_DQ_OUT  out  16  write data.
- RAM_DQ_OE  out  1  high = drive RAM_DQ_OUT onto the data bus.
- RAM_OE, RAM_WE, RAM_CS  out  1 each  SRAM active-low controls.
- BUSY  out  1  FIFO non-empty or column write in progress.
- DROP  out  1  one-cycle pulse when a sample with SAMPLE_X > 639 is discarded.

## Operation
- The FIFO accepts a sample on any cycle where SAMPLE_VALID and SAMPLE_READY are both high.
- SAMPLE_Y > 399 is clamped to 399 at the FIFO input.
- SAMPLE_X > 639 is popped without any write, and DROP pulses.
- Address mapping for row y:
  - Block k = y/16.
  - Word w = 0 when k = 0, otherwise 25 − k.
  - Bit = 15 − (y mod 16).
  - Column base = x·25; RAM_ADDR = base + w.
- Column write: words 0..24 are written in ascending order. The target word gets a one-hot data value; every other word gets 0x0000.
- Bus owner is either VGA or WRITER; reset selects VGA.
  - While owner = VGA, RAM_ADDR, RAM_OE, RAM_WE and RAM_CS equal the VGA inputs combinationally, and RAM_DQ_OE = 0.
- FSM states and transitions:
  - IDLE: go to TURN when the FIFO is non-empty and ACCESS_OK = 1.
  - TURN: owner = WRITER; CS = OE = WE = 1; RAM_DQ_OE = 0. Lasts one cycle; this is the bus turnaround.
  - SETUP: CS = 0, OE = 1, WE = 1; address and data valid; RAM_DQ_OE = 1.
  - STROBE: WE = 0.
  - RELEASE: WE = 1; address and data held.
    - Last word → POP.
    - Otherwise, if ACCESS_OK = 0 → PARK.
    - Otherwise → SETUP with the word index incremented.
  - POP: pop the FIFO.
    - FIFO non-empty and ACCESS_OK = 1 → SETUP, word index = 0.
    - Otherwise → PARK.
  - PARK: CS = 1; RAM_DQ_OE = 0; owner returns to VGA on the next cycle.
    - If a column is still in progress, its word index is retained. The next grant resumes at that word via TURN → SETUP.
    - Otherwise → IDLE.
- The FIFO head is not popped until all 25 words of its column are written.

## Timing
- Reset values:
  - SAMPLE_READY = 0 while reset is asserted, 1 after reset.
  - BUSY = 0, DROP = 0, RAM_DQ_OE = 0, RAM_DQ_OUT = 0.
  - Owner = VGA, so RAM_* outputs mirror the VGA inputs.
- Per-word cost is 3 cycles (SETUP, STROBE, RELEASE). A full column is TURN + 75 + POP + PARK = 78 cycles.
- Back-to-back samples inside one window cost 76 cycles each.
- When ACCESS_OK falls mid-STROBE, the current word completes. The bus is returned at most 3 cycles later.
- FIFO full: SAMPLE_READY = 0 combinationally from the count. A push and a pop in the same cycle when full is legal; the count is unchanged.
- Reset asserted mid-column: the write aborts immediately, the FIFO empties, and the partially written column is left as-is.

## Structure
- Shared package `scope_pkg` holds:
  - WORDS_PER_COL, NUM_COLS, NUM_ROWS.
  - The owner enum {OWN_VGA, OWN_WR}.
  - The FSM state enum.
  - The row-to-word/bit mapping function, shared with the VGA reader's convention.
- Sub-module `sample_fifo`: synchronous FIFO of {x[9:0], y[8:0]} with count, full and empty outputs, asynchronous reset.

## Test plan
- Sample (x=0, y=0) with ACCESS_OK = 1:
  - Address 0 is written with 0x8000.
  - Addresses 1..24 are written with 0x0000.
  - BUSY falls after 78 cycles.
- Sample (x=2, y=17) → address 74 (50 + 24) gets 0x4000; the other 24 words of column 2 get 0x0000.
- ACCESS_OK = 0 with 5 pushes:
  - SAMPLE_READY drops after the 4th push.
  - No RAM_WE pulses occur, and RAM_* track the VGA inputs exactly.
- ACCESS_OK falls after word 10 STROBE:
  - Word 10 completes, then PARK and the bus returns to VGA.
  - On the next window the write resumes at word 11 with no duplicate writes.
- SAMPLE_X = 700 → DROP pulses once, no RAM_WE activity; SAMPLE_Y = 450 → writes the same data as y = 399.
- MASTER_RST asserted during STROBE:
  - RAM_WE and RAM_CS return to the VGA inputs immediately, and RAM_DQ_OE = 0.
  - BUSY = 0 and the FIFO is empty after reset.
